dram_cache: RTL

DRAM_CACHE -- requirements
Module: dram_cache

---
 rtl/dram_cache.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/dram_cache.sv
// Direct-mapped, write-through, write-no-allocate one-word-line cache between a core and memory.
// Optional hit/miss statistics counters are enabled by defining DRAM_CACHE_STATS_EN.
module dram_cache #(
    parameter int unsigned INDEX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] addr_dram,
    input  logic [31:0] din_dram,
    input  logic        rw_dram,
    input  logic        valid_dram,
    output logic [31:0] dout_dram,
    output logic        ready_dram,
    output logic [26:0] cpu_req_addr,
    output logic [31:0] cpu_req_data,
    output logic        cpu_req_rw,
    output logic        cpu_req_valid,
    input  logic [31:0] cpu_res_data,
    input  logic        cpu_res_ready
`ifdef DRAM_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned WORD_W = 25;
    localparam int unsigned TAG_W  = WORD_W - INDEX_W;
    localparam int unsigned LINES  = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        WR_WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [31:0]         din_q, din_d;
    logic                rw_q, rw_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [31:0]         dout_q, dout_d;
    logic                ready_q, ready_d;
    logic [26:0]         req_addr_q, req_addr_d;
    logic [31:0]         req_data_q, req_data_d;
    logic                req_rw_q, req_rw_d;
    logic                req_valid_q, req_valid_d;

    logic [TAG_W-1:0]    tag_mem [LINES];
    logic [31:0]         data_mem [LINES];
    logic [TAG_W-1:0]    rd_tag;
    logic [31:0]         rd_data;
    logic                mem_re;
    logic                mem_we;
    logic [31:0]         mem_wdata;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic                unused_addr_lsb;

    assign idx             = word_q[INDEX_W-1:0];
    assign tag             = word_q[WORD_W-1:INDEX_W];
    assign hit             = valid_q[idx] && (rd_tag == tag);
    assign unused_addr_lsb = ^addr_dram[1:0];

    // Tag/data arrays: synchronous read addressed straight from the request, contents never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= mem_wdata;
        end
        if (mem_re) begin
            rd_tag  <= tag_mem[addr_dram[INDEX_W+1:2]];
            rd_data <= data_mem[addr_dram[INDEX_W+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            din_q       <= '0;
            rw_q        <= 1'b0;
            valid_q     <= '0;
            dout_q      <= '0;
            ready_q     <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_rw_q    <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            din_q       <= din_d;
            rw_q        <= rw_d;
            valid_q     <= valid_d;
            dout_q      <= dout_d;
            ready_q     <= ready_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_rw_q    <= req_rw_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Outputs are registered: each strobe is raised together with the transition into its state.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        din_d       = din_q;
        rw_d        = rw_q;
        valid_d     = valid_q;
        dout_d      = dout_q;
        ready_d     = 1'b0;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_rw_d    = req_rw_q;
        req_valid_d = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = din_q;

        case (state_q)
            IDLE: begin
                if (valid_dram) begin
                    word_d  = addr_dram[26:2];
                    din_d   = din_dram;
                    rw_d    = rw_dram;
                    mem_re  = 1'b1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (rw_q) begin
                    mem_we      = hit;
                    req_valid_d = 1'b1;
                    req_rw_d    = 1'b1;
                    req_addr_d  = {word_q, 2'b00};
                    req_data_d  = din_q;
                    state_d     = WR_WAIT;
                end else if (hit) begin
                    dout_d  = rd_data;
                    ready_d = 1'b1;
                    state_d = RESP;
                end else begin
                    req_valid_d = 1'b1;
                    req_rw_d    = 1'b0;
                    req_addr_d  = {word_q, 2'b00};
                    state_d     = MISS_REQ;
                end
            end
            MISS_REQ: begin
                state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (cpu_res_ready) begin
                    mem_we       = 1'b1;
                    mem_wdata    = cpu_res_data;
                    valid_d[idx] = 1'b1;
                    dout_d       = cpu_res_data;
                    ready_d      = 1'b1;
                    state_d      = RESP;
                end
            end
            WR_WAIT: begin
                if (cpu_res_ready) begin
                    ready_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout_dram     = dout_q;
    assign ready_dram    = ready_q;
    assign cpu_req_addr  = req_addr_q;
    assign cpu_req_data  = req_data_q;
    assign cpu_req_rw    = req_rw_q;
    assign cpu_req_valid = req_valid_q;

`ifdef DRAM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Read hit/miss counters, saturating at all-ones.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP && !rw_q) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule
